tail_light_monitor: RTL and testbench
=====================================

Name: tail_light_monitor

Overview:
- Receive-side decoder for the six-lamp Thunderbird tail-light interface (la,lb,lc / ra,rb,rc).
- Samples lamp outputs every clock and classifies the vehicle mode: idle, left, right, both, brake or hazard.
- Flags lamp sequences that no legal transmitter can produce.
- Sits on the verification/diagnostic side, downstream of the tail-light controller.

Parameters:
- HOLD_CYCLES, 4: consecutive all-dark cycles before mode returns to IDLE (min 1).
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- la, lb, lc  input  1 each  left lamps (a inner, c outer).
- ra, rb, rc  input  1 each  right lamps.
- mode  output  3  IDLE=000, LEFT=001, RIGHT=010, BOTH=011, BRAKE=100, HAZARD=101.
- err  output  1  one-cycle pulse on an illegal pattern or transition.
- err_sticky  output  1  set by err, cleared only by reset.
- err_count  output  ERR_CNT_W  saturating count of err pulses.

Behaviour:
- Side pattern {a,b,c} legal values: 000, 100, 110, 111; any other value is illegal.
- Each side is checked independently against its own previous pattern prev.
- Legal transitions (prev->cur):
  - 000->000, 000->100, 000->111
  - 100->110, 100->111, 100->000
  - 110->111, 110->000
  - 111->111, 111->000
- Every other transition is illegal, including 100->100, 110->110, 000->110, 111->100 and 110->100.
- Registers: prev_l, prev_r (3b each), toggle_cnt (2b, saturating at 2), dark_cnt (saturating at HOLD_CYCLES), mode, err, err_sticky, err_count.
- Reset values: all zero; mode=IDLE, err=0, err_sticky=0, err_count=0.
- Each rising edge (inputs sampled at that edge; outputs valid after it, 1-cycle latency):
  - prev_l/prev_r <= current patterns.
  - err <= 1 if either side has an illegal pattern or illegal transition.
  - When err is raised, err_sticky <= 1 and err_count increments, saturating at all-ones.
  - On an error cycle, mode holds and toggle_cnt clears.
  - Otherwise mode is decided by first match, in this order:
    1. Both sides 111 now and both were 111: mode <= BRAKE; toggle_cnt <= 0.
    2. Both sides flip in lockstep (both 000->111 or both 111->000): toggle_cnt++. When toggle_cnt reaches 2 (the second consecutive lockstep flip), mode <= HAZARD. A cycle that is not a lockstep flip clears toggle_cnt.
    3. Left side in {100,110} and right side in {100,110}: mode <= BOTH.
    4. Only left side in {100,110}: mode <= LEFT.
    5. Only right side in {100,110}: mode <= RIGHT.
    6. Otherwise mode holds.
  - dark_cnt increments while all six lamps are 0 and clears otherwise.
  - When dark_cnt reaches HOLD_CYCLES, mode <= IDLE; this overrides the hold in rule 6.
- Boundaries:
  - The first lockstep 000->111 alone does not yield HAZARD. The next cycle decides: 111 again gives BRAKE, 000 gives HAZARD.
  - A turn sweep wrap 111->000 on one side only is a legal sweep end; mode stays LEFT or RIGHT.
  - err_count saturates and never wraps.
  - Asynchronous reset mid-sequence clears prev_* to 000. The first post-reset pattern is then checked against 000, so a 110 on the first cycle after reset is flagged.

Optional Feature:
- Macro SYNC_IN_EN.
- Defined: each of the six lamp inputs passes through a 2-flop synchronizer (reset to 0) before checking. Total latency becomes 3 cycles.
- Undefined: inputs are used directly, with 1-cycle latency.

Test Plan:
- Reset, then left sweep 000,100,110,111,000 repeated twice, right side dark -> mode=LEFT from the 100 cycle onward; err=0 throughout.
- Both sides 000 then 111 for 3 cycles -> mode=BRAKE one cycle after the second 111 sample; err_count=0.
- Both sides alternate 000/111 for 6 cycles -> mode=HAZARD after the second flip; release to all-dark -> mode=IDLE after 4 dark cycles.
- Left side pattern 010 -> err=1 for exactly one cycle; err_sticky=1; err_count=1; mode unchanged.
- Left 100 held for 2 cycles -> err on the second sample. Repeat 300 illegal events with ERR_CNT_W=8 -> err_count=255.
- Assert reset mid-sweep at left 110, release, apply 110 -> err=1 (illegal 000->110); mode=IDLE immediately after reset.

Source files
------------

// File: rtl/tail_light_monitor.sv
// Thunderbird tail-light receive monitor: classifies the vehicle mode and flags illegal lamp sequences.
// Latency 1 cycle, or 3 cycles with SYNC_IN_EN defined (2-flop input synchronizers); no backpressure.
module tail_light_monitor #(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 la,
    input  logic                 lb,
    input  logic                 lc,
    input  logic                 ra,
    input  logic                 rb,
    input  logic                 rc,
    output logic [2:0]           mode,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int DW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        LEFT   = 3'b001,
        RIGHT  = 3'b010,
        BOTH   = 3'b011,
        BRAKE  = 3'b100,
        HAZARD = 3'b101
    } mode_t;

    logic [5:0] lamps;

`ifdef SYNC_IN_EN
    logic [5:0] sync_1;
    logic [5:0] sync_2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {la, lb, lc, ra, rb, rc};
            sync_2 <= sync_1;
        end
    end

    assign lamps = sync_2;
`else
    assign lamps = {la, lb, lc, ra, rb, rc};
`endif

    function automatic logic pat_ok(input logic [2:0] p);
        return (p == 3'b000) || (p == 3'b100) || (p == 3'b110) || (p == 3'b111);
    endfunction

    // An illegal previous pattern was already reported when it arrived, so
    // leaving it is not counted as a second fault.
    function automatic logic trans_ok(input logic [2:0] p, input logic [2:0] c);
        logic ok;
        case (p)
            3'b000:  ok = (c == 3'b000) || (c == 3'b100) || (c == 3'b111);
            3'b100:  ok = (c == 3'b110) || (c == 3'b111) || (c == 3'b000);
            3'b110:  ok = (c == 3'b111) || (c == 3'b000);
            3'b111:  ok = (c == 3'b111) || (c == 3'b000);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    logic [2:0]           cur_l, cur_r;
    logic [2:0]           prev_l, prev_r;
    logic [1:0]           toggle_cnt, toggle_nxt;
    logic [DW-1:0]        dark_cnt, dark_nxt;
    mode_t                mode_q, mode_nxt;
    logic                 err_nxt;
    logic                 err_sticky_q;
    logic [ERR_CNT_W-1:0] err_count_q;
    logic                 turn_l, turn_r, lockstep, all_dark;

    assign cur_l = lamps[5:3];
    assign cur_r = lamps[2:0];

    always_comb begin
        err_nxt    = 1'b0;
        mode_nxt   = mode_q;
        toggle_nxt = 2'd0;
        dark_nxt   = '0;
        turn_l     = (cur_l == 3'b100) || (cur_l == 3'b110);
        turn_r     = (cur_r == 3'b100) || (cur_r == 3'b110);
        lockstep   = ((prev_l == 3'b000) && (cur_l == 3'b111) && (prev_r == 3'b000) && (cur_r == 3'b111))
                  || ((prev_l == 3'b111) && (cur_l == 3'b000) && (prev_r == 3'b111) && (cur_r == 3'b000));
        all_dark   = (cur_l == 3'b000) && (cur_r == 3'b000);

        err_nxt = !pat_ok(cur_l) || !trans_ok(prev_l, cur_l)
               || !pat_ok(cur_r) || !trans_ok(prev_r, cur_r);

        if (all_dark) begin
            dark_nxt = (dark_cnt == DW'(HOLD_CYCLES)) ? dark_cnt : dark_cnt + DW'(1);
        end

        if (!err_nxt) begin
            if ((cur_l == 3'b111) && (cur_r == 3'b111) && (prev_l == 3'b111) && (prev_r == 3'b111)) begin
                mode_nxt = BRAKE;
            end else if (lockstep) begin
                toggle_nxt = (toggle_cnt == 2'd2) ? 2'd2 : toggle_cnt + 2'd1;
                if (toggle_nxt == 2'd2) begin
                    mode_nxt = HAZARD;
                end
            end else if (turn_l && turn_r) begin
                mode_nxt = BOTH;
            end else if (turn_l) begin
                mode_nxt = LEFT;
            end else if (turn_r) begin
                mode_nxt = RIGHT;
            end else if (dark_nxt == DW'(HOLD_CYCLES)) begin
                mode_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_l       <= 3'b000;
            prev_r       <= 3'b000;
            toggle_cnt   <= 2'd0;
            dark_cnt     <= '0;
            mode_q       <= IDLE;
            err          <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            prev_l     <= cur_l;
            prev_r     <= cur_r;
            toggle_cnt <= toggle_nxt;
            dark_cnt   <= dark_nxt;
            mode_q     <= mode_nxt;
            err        <= err_nxt;
            if (err_nxt) begin
                err_sticky_q <= 1'b1;
                if (err_count_q != '1) begin
                    err_count_q <= err_count_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign mode       = mode_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_tail_light_monitor.sv
// Directed self-checking bench for tail_light_monitor (default build, 1-cycle latency).
module tb_tail_light_monitor;

    localparam logic [2:0] M_IDLE   = 3'b000;
    localparam logic [2:0] M_LEFT   = 3'b001;
    localparam logic [2:0] M_RIGHT  = 3'b010;
    localparam logic [2:0] M_BOTH   = 3'b011;
    localparam logic [2:0] M_BRAKE  = 3'b100;
    localparam logic [2:0] M_HAZARD = 3'b101;

    logic       clk;
    logic       reset;
    logic       la, lb, lc, ra, rb, rc;
    logic [2:0] mode;
    logic       err;
    logic       err_sticky;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    tail_light_monitor #(
        .HOLD_CYCLES(4),
        .ERR_CNT_W  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .la        (la),
        .lb        (lb),
        .lc        (lc),
        .ra        (ra),
        .rb        (rb),
        .rc        (rc),
        .mode      (mode),
        .err       (err),
        .err_sticky(err_sticky),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive both sides, let one rising edge sample them, settle 1 time unit.
    task automatic step(input logic [2:0] l, input logic [2:0] r);
        {la, lb, lc} = l;
        {ra, rb, rc} = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] sweep [5];
        sweep[0] = 3'b000; sweep[1] = 3'b100; sweep[2] = 3'b110;
        sweep[3] = 3'b111; sweep[4] = 3'b000;

        reset = 1'b1;
        {la, lb, lc, ra, rb, rc} = 6'b0;
        #12;
        chk("reset_mode", mode, M_IDLE);
        chk("reset_err", err, 0);
        chk("reset_sticky", err_sticky, 0);
        chk("reset_count", err_count, 0);
        reset = 1'b0;

        // Left turn sweep twice, right side dark; 111->000 wrap keeps LEFT.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 5; i++) begin
                step(sweep[i], 3'b000);
                chk("sweep_err", err, 0);
                if (rep == 0 && i == 0) chk("sweep_first_idle", mode, M_IDLE);
                else                    chk("sweep_left", mode, M_LEFT);
            end
        end

        // Brake: one lockstep 000->111 alone holds, the second 111 gives BRAKE.
        step(3'b000, 3'b000);
        step(3'b111, 3'b111);
        chk("brake_first_flip_holds", mode, M_LEFT);
        step(3'b111, 3'b111);
        chk("brake_mode", mode, M_BRAKE);
        step(3'b111, 3'b111);
        chk("brake_hold", mode, M_BRAKE);
        chk("brake_count", err_count, 0);

        // Hazard: 000,111 alternating; second consecutive flip gives HAZARD.
        step(3'b000, 3'b000);
        chk("hazard_flip1", mode, M_BRAKE);
        step(3'b111, 3'b111);
        chk("hazard_flip2", mode, M_HAZARD);
        step(3'b000, 3'b000);
        step(3'b111, 3'b111);
        step(3'b000, 3'b000);
        step(3'b111, 3'b111);
        chk("hazard_stay", mode, M_HAZARD);
        chk("hazard_err", err, 0);
        step(3'b000, 3'b000);
        step(3'b000, 3'b000);
        step(3'b000, 3'b000);
        chk("dark3_holds", mode, M_HAZARD);
        step(3'b000, 3'b000);
        chk("dark4_idle", mode, M_IDLE);

        // Illegal pattern 010 on the left while in LEFT.
        step(3'b100, 3'b000);
        chk("pre_err_left", mode, M_LEFT);
        step(3'b010, 3'b000);
        chk("bad_pat_err", err, 1);
        chk("bad_pat_sticky", err_sticky, 1);
        chk("bad_pat_count", err_count, 1);
        chk("bad_pat_mode", mode, M_LEFT);
        step(3'b000, 3'b000);
        chk("bad_pat_pulse_end", err, 0);
        chk("bad_pat_sticky_kept", err_sticky, 1);

        // 100 held two cycles is an illegal transition on the second sample.
        step(3'b100, 3'b000);
        chk("hold100_first", err, 0);
        step(3'b100, 3'b000);
        chk("hold100_second", err, 1);
        chk("hold100_count", err_count, 2);
        step(3'b000, 3'b000);
        chk("hold100_clear", err, 0);

        // 300 further illegal events saturate the counter at 255.
        for (int n = 0; n < 300; n++) begin
            step(3'b100, 3'b000);
            step(3'b100, 3'b000);
            step(3'b000, 3'b000);
        end
        chk("sat_count", err_count, 255);
        chk("sat_sticky", err_sticky, 1);

        // Right-only and both-side turns.
        step(3'b000, 3'b100);
        chk("right_mode", mode, M_RIGHT);
        step(3'b100, 3'b110);
        chk("both_mode", mode, M_BOTH);
        chk("both_err", err, 0);
        step(3'b000, 3'b000);

        // Async reset mid-sweep at left 110, then 110 again is 000->110.
        step(3'b100, 3'b000);
        step(3'b110, 3'b000);
        chk("pre_reset_left", mode, M_LEFT);
        reset = 1'b1;
        #1;
        chk("async_reset_mode", mode, M_IDLE);
        chk("async_reset_count", err_count, 0);
        chk("async_reset_sticky", err_sticky, 0);
        #1;
        reset = 1'b0;
        step(3'b110, 3'b000);
        chk("post_reset_err", err, 1);
        chk("post_reset_count", err_count, 1);
        chk("post_reset_mode", mode, M_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
